// File: rtl/fetch_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pc_unit: PC register and single-entry instruction fetch stage.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Branch_Flag_i,
  input  logic [31:0] Branch_Target_i,
  input  logic        Stall_i,
  input  logic        Imem_Ready_i,
  input  logic [31:0] Imem_Data_i,
  output logic        Imem_Req_o,
  output logic [31:0] Imem_Addr_o,
  output logic [31:0] Instr_o,
  output logic        Instr_Valid_o,
  output logic [31:0] PC_o,
  output logic [31:0] PC_Plus_4_o,
  output logic        Misalign_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    EMPTY = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        misalign_q, misalign_d;

  logic        w_consume;
  logic        w_redirect;
  logic        w_accept;

  // The redirect mux is combinational so the target goes out in the same cycle.
  always_comb begin
    w_consume   = (state_q == FULL) && !Stall_i;
    Imem_Req_o  = (state_q == EMPTY) || w_consume;
    w_redirect  = w_consume && Branch_Flag_i;
    Imem_Addr_o = w_redirect ? {Branch_Target_i[31:2], 2'b00} : fetch_pc_q;
    w_accept    = Imem_Req_o && Imem_Ready_i;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    misalign_d = w_redirect && (Branch_Target_i[1:0] != 2'b00);
    case (state_q)
      BOOT: state_d = EMPTY;
      EMPTY, FULL: begin
        if (w_accept) begin
          instr_d    = Imem_Data_i;
          pc_d       = Imem_Addr_o;
          pc4_d      = Imem_Addr_o + 32'd4;
          fetch_pc_d = Imem_Addr_o + 32'd4;
          state_d    = FULL;
        end else if (Imem_Req_o) begin
          // Latch the outstanding address so it stays stable until accepted.
          fetch_pc_d = Imem_Addr_o;
          instr_d    = NOP_INSTR;
          state_d    = EMPTY;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      pc4_q      <= RESET_PC + 32'd4;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      misalign_q <= misalign_d;
    end
  end

  assign Instr_o       = instr_q;
  assign Instr_Valid_o = (state_q == FULL);
  assign PC_o          = pc_q;
  assign PC_Plus_4_o   = pc4_q;
  assign Misalign_o    = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_pc_unit: random fetch-stream bench with a scoreboard.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fetch_pc_unit;
  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          NITEMS    = 200;
  localparam int          NDEC      = NITEMS + 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        Branch_Flag_i;
  logic [31:0] Branch_Target_i;
  logic        Stall_i;
  logic        Imem_Ready_i;
  logic [31:0] Imem_Data_i;
  logic        Imem_Req_o;
  logic [31:0] Imem_Addr_o;
  logic [31:0] Instr_o;
  logic        Instr_Valid_o;
  logic [31:0] PC_o;
  logic [31:0] PC_Plus_4_o;
  logic        Misalign_o;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset),
    .Branch_Flag_i(Branch_Flag_i), .Branch_Target_i(Branch_Target_i),
    .Stall_i(Stall_i), .Imem_Ready_i(Imem_Ready_i), .Imem_Data_i(Imem_Data_i),
    .Imem_Req_o(Imem_Req_o), .Imem_Addr_o(Imem_Addr_o), .Instr_o(Instr_o),
    .Instr_Valid_o(Instr_Valid_o), .PC_o(PC_o), .PC_Plus_4_o(PC_Plus_4_o),
    .Misalign_o(Misalign_o)
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  assign Imem_Data_i = mem_word(Imem_Addr_o);

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] exp_pc[NDEC];
  bit          dec_taken[NDEC];
  logic [31:0] dec_tgt[NDEC];

  int  tests = 0, fails = 0;
  int  consumed = 0, acc_k = 0, drv_k = 0;
  bit  running = 1'b0;
  bit  exp_mis = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order stream: each item follows the previous one by +4 unless
  // the decision taken while consuming it redirects to an aligned target.
  task automatic build_model();
    exp_pc[0] = RESET_PC;
    for (int k = 0; k < NDEC - 1; k++) begin
      dec_taken[k] = ($urandom % 4) == 0;
      dec_tgt[k]   = $urandom;
      if (k == 20) begin dec_taken[k] = 1'b1; dec_tgt[k] = 32'hFFFF_FFF8; end
      if (k == 40) begin dec_taken[k] = 1'b1; dec_tgt[k] = 32'h0040_0102; end
      if (k == 60) begin dec_taken[k] = 1'b1; dec_tgt[k] = 32'h0040_0100; end
      exp_pc[k+1] = dec_taken[k] ? (dec_tgt[k] & 32'hFFFF_FFFC) : exp_pc[k] + 32'd4;
      sb_q.push_back('{pc: exp_pc[k], instr: mem_word(exp_pc[k])});
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, {31'd0, Instr_Valid_o}, 32'd0);
    check({tag, "_instr"}, Instr_o, NOP_INSTR);
    check({tag, "_pc"}, PC_o, RESET_PC);
    check({tag, "_pc4"}, PC_Plus_4_o, RESET_PC + 32'd4);
    check({tag, "_req"}, {31'd0, Imem_Req_o}, 32'd0);
    check({tag, "_mis"}, {31'd0, Misalign_o}, 32'd0);
  endtask

  // Driver: random stall/ready; branch decisions applied on consume only.
  always @(posedge clk) begin
    if (running) begin
      #1;
      Stall_i      = ($urandom % 4) == 0;
      Imem_Ready_i = ($urandom % 3) != 0;
      if (Instr_Valid_o && !Stall_i && drv_k < NDEC) begin
        Branch_Flag_i   = dec_taken[drv_k];
        Branch_Target_i = dec_tgt[drv_k];
        drv_k++;
      end else begin
        Branch_Flag_i   = $urandom;
        Branch_Target_i = $urandom;
      end
    end
  end

  // Monitor: compares DUT activity against the precomputed stream.
  always @(negedge clk) begin
    if (running) begin
      bit cons;
      cons = Instr_Valid_o && !Stall_i;
      check("misalign_pulse", {31'd0, Misalign_o}, {31'd0, exp_mis});
      exp_mis = cons && Branch_Flag_i && (Branch_Target_i[1:0] != 2'b00);
      if (!Instr_Valid_o) check("nop_when_invalid", Instr_o, NOP_INSTR);
      if (Instr_Valid_o && Stall_i) check("no_req_on_stall", {31'd0, Imem_Req_o}, 32'd0);
      if (Imem_Req_o && Imem_Ready_i) begin
        if (acc_k < NDEC) check("fetch_addr", Imem_Addr_o, exp_pc[acc_k]);
        acc_k++;
      end
      if (cons) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL scoreboard_empty: got consume expected none");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("pc", PC_o, e.pc);
          check("instr", Instr_o, e.instr);
          check("pc_plus_4", PC_Plus_4_o, e.pc + 32'd4);
        end
        consumed++;
      end
    end
  end

  initial begin
    int cyc;
    build_model();
    reset = 1'b0; Stall_i = 1'b0; Branch_Flag_i = 1'b0;
    Branch_Target_i = 32'h0; Imem_Ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk) reset = 1'b1;
    #1 check("boot_no_req", {31'd0, Imem_Req_o}, 32'd0);
    running = 1'b1;

    cyc = 0;
    while (consumed < NITEMS && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    if (consumed < NITEMS) begin
      tests++; fails++;
      $display("FAIL stream_timeout: got %0d items expected %0d", consumed, NITEMS);
    end

    @(negedge clk) running = 1'b0;
    @(posedge clk) #1;
    Stall_i = 1'b0; Branch_Flag_i = 1'b0; Imem_Ready_i = 1'b0;
    @(posedge clk) #1;
    check("pending_req", {31'd0, Imem_Req_o}, 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_values("midreset");
    @(negedge clk) begin reset = 1'b1; Imem_Ready_i = 1'b1; end
    #1 check("reboot_no_req", {31'd0, Imem_Req_o}, 32'd0);
    @(posedge clk) #1;
    check("reboot_req", {31'd0, Imem_Req_o}, 32'd1);
    check("reboot_addr", Imem_Addr_o, RESET_PC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and instruction-fetch stage that consumes the taken-branch decision and branch/jump target from the branch-control stage.
- Owns the architectural PC and drives a valid/ready request interface to instruction memory.
- Holds one fetched instruction for decode and prefetches the next instruction while that one is held.
- Redirects fetch on a taken branch, JAL or JALR without issuing any wrong-path request.

Parameters:
- RESET_PC, 32'h0040_0000, address of the first fetch after reset.
- NOP_INSTR, 32'h0000_0013, value driven on Instr_o whenever Instr_Valid_o=0.

Ports:
- clk  input  1  stage clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Branch_Flag_i  input  1  taken-branch/jump decision for the instruction currently on Instr_o.
- Branch_Target_i  input  32  target address, valid when Branch_Flag_i=1.
- Stall_i  input  1  decode/execute cannot accept the instruction currently on Instr_o.
- Imem_Ready_i  input  1  instruction memory accepts the request and returns data in the same cycle.
- Imem_Data_i  input  32  instruction word, valid when Imem_Req_o and Imem_Ready_i are both high.
- Imem_Req_o  output  1  fetch request.
- Imem_Addr_o  output  32  fetch address.
- Instr_o  output  32  held instruction.
- Instr_Valid_o  output  1  Instr_o and PC_o are valid.
- PC_o  output  32  address of Instr_o.
- PC_Plus_4_o  output  32  PC_o+4, used as the JAL/JALR link value.
- Misalign_o  output  1  one-cycle pulse when a taken target has bits [1:0] not equal to 0.

Behaviour:
- Reset (async assert, active-low) forces these values:
  - State=BOOT, Fetch_PC=RESET_PC.
  - Instr_Valid_o=0, Instr_o=NOP_INSTR, PC_o=RESET_PC, PC_Plus_4_o=RESET_PC+4.
  - Imem_Req_o=0, Misalign_o=0.
- States:
  - BOOT: one cycle after reset release. No request is issued. Always moves to EMPTY.
  - EMPTY: no held instruction; Imem_Req_o=1.
  - FULL: holds one instruction.
- Consume, defined as consume = FULL & ~Stall_i.
- Imem_Req_o = EMPTY | consume.
  - FULL with Stall_i=1 issues no request; there is no prefetch beyond one entry.
- redirect = consume & Branch_Flag_i.
  - Branch_Flag_i is ignored when the stage is not consuming.
- Imem_Addr_o = redirect ? {Branch_Target_i[31:2],2'b00} : Fetch_PC.
  - This path is combinational, so no wrong-path request is ever issued.
- Handshake: accept = Imem_Req_o & Imem_Ready_i. On accept:
  - Instr_o <= Imem_Data_i.
  - PC_o <= Imem_Addr_o.
  - PC_Plus_4_o <= Imem_Addr_o+4.
  - Fetch_PC <= Imem_Addr_o+4.
  - Next state = FULL.
- Request issued but not accepted (Imem_Ready_i=0):
  - Fetch_PC <= Imem_Addr_o.
  - On consume, next state = EMPTY.
  - The address therefore stays stable on every following cycle until accepted.
- Transitions:
  - EMPTY, accept → FULL. EMPTY, no accept → EMPTY.
  - FULL & Stall_i → FULL; all outputs held.
  - FULL & consume & accept → FULL with the new instruction, giving back-to-back 1 instruction/cycle.
  - FULL & consume & ~accept → EMPTY.
- Instr_o = NOP_INSTR whenever the next state is EMPTY.
- Latency: memory data appears on Instr_o one cycle after the accept edge.
- Arithmetic is 32-bit modulo. Fetch_PC at 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Misalign_o = redirect & (Branch_Target_i[1:0] != 0), registered as a one-cycle pulse. The fetch still proceeds at the target with bits [1:0] forced to 00.
- Simultaneous events:
  - Redirect has priority over sequential Fetch_PC.
  - Stall_i=1 masks Branch_Flag_i in the same cycle.
- Reset mid-request: any pending request is abandoned and the next fetch is RESET_PC after BOOT.

Test Plan:
- Reset release, Imem_Ready_i=1, Stall_i=0 → BOOT cycle with no request; then requests to 0x0040_0000, 0x0040_0004, 0x0040_0008 on consecutive cycles; Instr_Valid_o continuous from cycle 2.
- Held instruction at PC_o=0x0040_0004 with Branch_Flag_i=1, Branch_Target_i=0x0040_0100 and consume → same-cycle Imem_Addr_o=0x0040_0100; next PC_o=0x0040_0100; address 0x0040_0008 never requested.
- Stall_i=1 for 3 cycles while FULL → Imem_Req_o=0 and PC_o/Instr_o unchanged; Branch_Flag_i=1 during the stall is ignored; sequential fetch resumes on release.
- Redirect to 0x0040_0200 with Imem_Ready_i=0 for 2 cycles → Imem_Addr_o=0x0040_0200 on all 3 cycles; Instr_Valid_o=0 with Instr_o=NOP_INSTR until accept.
- Taken target 0x0040_0102 → Misalign_o pulses for one cycle; fetch issued to 0x0040_0100.
- Reset asserted while Imem_Req_o=1 and Imem_Ready_i=0 → outputs immediately return to reset values; after release, first request is 0x0040_0000.
